// File: rtl/rv32_bus_switch_if.sv
// Bundle of the two requester ports (A = LSU, B = fetch) and the shared downstream port X.
// The switch uses the slave modport; the surrounding fabric/bench drives through master.
interface rv32_bus_switch_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] i_a_req_addr;
  logic [XLEN-1:0] i_a_req_data;
  logic [3:0]      i_a_req_ben;
  logic            i_a_req_we;
  logic            i_a_req_re;
  logic            i_a_req_src;
  logic            i_a_req_priv;
  logic            i_a_req_rvso;
  logic [XLEN-1:0] o_a_rsp_data;
  logic            o_a_rsp_ack;
  logic            o_a_rsp_err;

  logic [XLEN-1:0] i_b_req_addr;
  logic [XLEN-1:0] i_b_req_data;
  logic [3:0]      i_b_req_ben;
  logic            i_b_req_we;
  logic            i_b_req_re;
  logic            i_b_req_src;
  logic            i_b_req_priv;
  logic            i_b_req_rvso;
  logic [XLEN-1:0] o_b_rsp_data;
  logic            o_b_rsp_ack;
  logic            o_b_rsp_err;

  logic [XLEN-1:0] o_x_req_addr;
  logic [XLEN-1:0] o_x_req_data;
  logic [3:0]      o_x_req_ben;
  logic            o_x_req_we;
  logic            o_x_req_re;
  logic            o_x_req_src;
  logic            o_x_req_priv;
  logic            o_x_req_rvso;
  logic [XLEN-1:0] i_x_rsp_data;
  logic            i_x_rsp_ack;
  logic            i_x_rsp_err;

  modport slave (
    input  i_a_req_addr, i_a_req_data, i_a_req_ben, i_a_req_we, i_a_req_re,
           i_a_req_src, i_a_req_priv, i_a_req_rvso,
    output o_a_rsp_data, o_a_rsp_ack, o_a_rsp_err,
    input  i_b_req_addr, i_b_req_data, i_b_req_ben, i_b_req_we, i_b_req_re,
           i_b_req_src, i_b_req_priv, i_b_req_rvso,
    output o_b_rsp_data, o_b_rsp_ack, o_b_rsp_err,
    output o_x_req_addr, o_x_req_data, o_x_req_ben, o_x_req_we, o_x_req_re,
           o_x_req_src, o_x_req_priv, o_x_req_rvso,
    input  i_x_rsp_data, i_x_rsp_ack, i_x_rsp_err
  );

  modport master (
    output i_a_req_addr, i_a_req_data, i_a_req_ben, i_a_req_we, i_a_req_re,
           i_a_req_src, i_a_req_priv, i_a_req_rvso,
    input  o_a_rsp_data, o_a_rsp_ack, o_a_rsp_err,
    output i_b_req_addr, i_b_req_data, i_b_req_ben, i_b_req_we, i_b_req_re,
           i_b_req_src, i_b_req_priv, i_b_req_rvso,
    input  o_b_rsp_data, o_b_rsp_ack, o_b_rsp_err,
    input  o_x_req_addr, o_x_req_data, o_x_req_ben, o_x_req_we, o_x_req_re,
           o_x_req_src, o_x_req_priv, o_x_req_rvso,
    output i_x_rsp_data, i_x_rsp_ack, i_x_rsp_err
  );
endinterface

// File: rtl/rv32_bus_switch.sv
// Two-into-one bus switch: LSU port A has fixed priority over fetch port B onto the CPU bus X.
// Grant is held until downstream ack/err; the response is routed to the granted port only.
module rv32_bus_switch #(
  parameter int unsigned XLEN             = 32,
  parameter bit          PORT_A_READ_ONLY = 1'b0,
  parameter bit          PORT_B_READ_ONLY = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  rv32_bus_switch_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_A = 2'd1,
    ST_BUSY_B = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic pend_a_rd_q, pend_a_wr_q, pend_b_rd_q, pend_b_wr_q;
  logic pend_a_rd_d, pend_a_wr_d, pend_b_rd_d, pend_b_wr_d;
  logic x_re_q, x_we_q, x_re_d, x_we_d;

  logic a_we_live, b_we_live;
  logic a_rd, a_wr, b_rd, b_wr;
  logic a_has_req, b_has_req, rsp_done;
  logic grant_a, grant_b;
  logic busy_a, busy_b;

  // Write strobes on a read-only port are dropped before they can reach anything.
  assign a_we_live = bus.i_a_req_we & !PORT_A_READ_ONLY;
  assign b_we_live = bus.i_b_req_we & !PORT_B_READ_ONLY;

  assign a_rd      = pend_a_rd_q | bus.i_a_req_re;
  assign a_wr      = pend_a_wr_q | a_we_live;
  assign b_rd      = pend_b_rd_q | bus.i_b_req_re;
  assign b_wr      = pend_b_wr_q | b_we_live;
  assign a_has_req = a_rd | a_wr;
  assign b_has_req = b_rd | b_wr;
  assign rsp_done  = bus.i_x_rsp_ack | bus.i_x_rsp_err;

  assign busy_a    = (state_q == ST_BUSY_A);
  assign busy_b    = (state_q == ST_BUSY_B);
  assign grant_a   = (state_q == ST_IDLE) && (state_d == ST_BUSY_A);
  assign grant_b   = (state_q == ST_IDLE) && (state_d == ST_BUSY_B);

  // State, pending flags and downstream strobes.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      pend_a_rd_q <= 1'b0;
      pend_a_wr_q <= 1'b0;
      pend_b_rd_q <= 1'b0;
      pend_b_wr_q <= 1'b0;
      x_re_q      <= 1'b0;
      x_we_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_a_rd_q <= pend_a_rd_d;
      pend_a_wr_q <= pend_a_wr_d;
      pend_b_rd_q <= pend_b_rd_d;
      pend_b_wr_q <= pend_b_wr_d;
      x_re_q      <= x_re_d;
      x_we_q      <= x_we_d;
    end
  end

  // Next-state: fixed priority A over B, grant held until ack or error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (a_has_req) begin
          state_d = ST_BUSY_A;
        end else if (b_has_req) begin
          state_d = ST_BUSY_B;
        end
      end
      ST_BUSY_A, ST_BUSY_B: begin
        if (rsp_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes fire only on the grant transition; strobes on the granted port are ignored.
  always_comb begin
    x_re_d      = 1'b0;
    x_we_d      = 1'b0;
    pend_a_rd_d = pend_a_rd_q | (bus.i_a_req_re & !busy_a);
    pend_a_wr_d = pend_a_wr_q | (a_we_live & !busy_a);
    pend_b_rd_d = pend_b_rd_q | (bus.i_b_req_re & !busy_b);
    pend_b_wr_d = pend_b_wr_q | (b_we_live & !busy_b);
    if (grant_a) begin
      x_re_d      = a_rd;
      x_we_d      = a_wr & !PORT_A_READ_ONLY;
      pend_a_rd_d = 1'b0;
      pend_a_wr_d = 1'b0;
    end else if (grant_b) begin
      x_re_d      = b_rd;
      x_we_d      = b_wr & !PORT_B_READ_ONLY;
      pend_b_rd_d = 1'b0;
      pend_b_wr_d = 1'b0;
    end
  end

  assign bus.o_x_req_re   = x_re_q;
  assign bus.o_x_req_we   = x_we_q;

  // Request fields follow port B only while B owns the bus.
  assign bus.o_x_req_addr = busy_b ? bus.i_b_req_addr : bus.i_a_req_addr;
  assign bus.o_x_req_data = busy_b ? bus.i_b_req_data : bus.i_a_req_data;
  assign bus.o_x_req_ben  = busy_b ? bus.i_b_req_ben  : bus.i_a_req_ben;
  assign bus.o_x_req_src  = busy_b ? bus.i_b_req_src  : bus.i_a_req_src;
  assign bus.o_x_req_priv = busy_b ? bus.i_b_req_priv : bus.i_a_req_priv;
  assign bus.o_x_req_rvso = busy_b ? bus.i_b_req_rvso : bus.i_a_req_rvso;

  assign bus.o_a_rsp_ack  = bus.i_x_rsp_ack & busy_a;
  assign bus.o_a_rsp_err  = bus.i_x_rsp_err & busy_a;
  assign bus.o_a_rsp_data = busy_a ? bus.i_x_rsp_data : {XLEN{1'b0}};
  assign bus.o_b_rsp_ack  = bus.i_x_rsp_ack & busy_b;
  assign bus.o_b_rsp_err  = bus.i_x_rsp_err & busy_b;
  assign bus.o_b_rsp_data = busy_b ? bus.i_x_rsp_data : {XLEN{1'b0}};

endmodule

// File: tb/tb_rv32_bus_switch.sv
// Directed plus randomized bench for rv32_bus_switch; expected grant order, strobes and
// routed responses come from a transaction-level model of the priority rules.
module tb_rv32_bus_switch;

  localparam int unsigned XLEN = 32;
  localparam bit A_RO = 1'b0;
  localparam bit B_RO = 1'b1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ben;
    logic        src;
    logic        priv;
    logic        rvso;
  } req_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  rv32_bus_switch_if #(.XLEN(XLEN)) bus ();

  rv32_bus_switch #(
    .XLEN(XLEN),
    .PORT_A_READ_ONLY(A_RO),
    .PORT_B_READ_ONLY(B_RO)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.addr = $urandom;
    r.data = $urandom;
    r.ben  = 4'($urandom);
    r.src  = 1'($urandom);
    r.priv = 1'($urandom);
    r.rvso = 1'($urandom);
    return r;
  endfunction

  function automatic req_t mk_req(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [3:0] ben);
    req_t r;
    r.addr = addr; r.data = data; r.ben = ben;
    r.src = 1'b0; r.priv = 1'b1; r.rvso = 1'b0;
    return r;
  endfunction

  task automatic set_a(input req_t r);
    bus.i_a_req_addr = r.addr; bus.i_a_req_data = r.data; bus.i_a_req_ben = r.ben;
    bus.i_a_req_src  = r.src;  bus.i_a_req_priv = r.priv; bus.i_a_req_rvso = r.rvso;
  endtask

  task automatic set_b(input req_t r);
    bus.i_b_req_addr = r.addr; bus.i_b_req_data = r.data; bus.i_b_req_ben = r.ben;
    bus.i_b_req_src  = r.src;  bus.i_b_req_priv = r.priv; bus.i_b_req_rvso = r.rvso;
  endtask

  task automatic clr_strobes();
    bus.i_a_req_re = 1'b0; bus.i_a_req_we = 1'b0;
    bus.i_b_req_re = 1'b0; bus.i_b_req_we = 1'b0;
  endtask

  task automatic set_rsp(input logic ack, input logic err, input logic [31:0] d);
    bus.i_x_rsp_ack = ack; bus.i_x_rsp_err = err; bus.i_x_rsp_data = d;
    #1;
  endtask

  task automatic chk_x(input string tag, input req_t r, input logic re, input logic we);
    chk({tag, ".re"},   64'(bus.o_x_req_re),   64'(re));
    chk({tag, ".we"},   64'(bus.o_x_req_we),   64'(we));
    chk({tag, ".addr"}, 64'(bus.o_x_req_addr), 64'(r.addr));
    chk({tag, ".data"}, 64'(bus.o_x_req_data), 64'(r.data));
    chk({tag, ".ben"},  64'(bus.o_x_req_ben),  64'(r.ben));
    chk({tag, ".attr"}, 64'({bus.o_x_req_src, bus.o_x_req_priv, bus.o_x_req_rvso}),
        64'({r.src, r.priv, r.rvso}));
  endtask

  task automatic chk_strb(input string tag, input logic re, input logic we);
    chk({tag, ".strb"}, 64'({bus.o_x_req_re, bus.o_x_req_we}), 64'({re, we}));
  endtask

  // p: 0 = port A owns the response, 1 = port B, -1 = nobody.
  task automatic chk_rsp(input string tag, input int p, input logic ack, input logic err,
                         input logic [31:0] d);
    chk({tag, ".a_rsp"}, {31'd0, bus.o_a_rsp_ack, bus.o_a_rsp_err, bus.o_a_rsp_data},
        (p == 0) ? {31'd0, ack, err, d} : 64'd0);
    chk({tag, ".b_rsp"}, {31'd0, bus.o_b_rsp_ack, bus.o_b_rsp_err, bus.o_b_rsp_data},
        (p == 1) ? {31'd0, ack, err, d} : 64'd0);
  endtask

  task automatic wait_strobe(input string tag);
    for (int k = 0; k < 6; k++) begin
      if (bus.o_x_req_re || bus.o_x_req_we) break;
      tick();
    end
    chk({tag, ".seen"}, 64'(bus.o_x_req_re | bus.o_x_req_we), 64'd1);
  endtask

  req_t ra, rb, rq;
  int   order[$];
  int   p, dly;
  logic a_re, a_we, b_re, b_we, inj, use_err;
  logic exp_re[2];
  logic exp_we[2];
  logic [31:0] rdata;

  initial begin
    clr_strobes();
    set_b(mk_req(32'hABCD, 32'h0, 4'h0));
    ra = mk_req(32'h1234, 32'h5678, 4'hF);
    set_a(ra);
    set_rsp(1'b1, 1'b1, 32'hFFFF_FFFF);

    // Reset state: no strobes, responses gated off, request fields follow port A.
    chk_strb("reset", 1'b0, 1'b0);
    chk_rsp("reset", -1, 1'b0, 1'b0, 32'h0);
    chk_x("reset", ra, 1'b0, 1'b0);
    tick();
    set_rsp(1'b0, 1'b0, 32'h0);
    rstn = 1'b1;
    tick();

    // Single read on A.
    ra = mk_req(32'h1000, 32'h0, 4'hF);
    set_a(ra);
    bus.i_a_req_re = 1'b1;
    tick();
    clr_strobes();
    chk_x("rd.c2", ra, 1'b1, 1'b0);
    tick();
    chk_strb("rd.c3", 1'b0, 1'b0);
    tick();
    set_rsp(1'b1, 1'b0, 32'hDEAD_BEEF);
    chk_rsp("rd.c4", 0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    tick();
    set_rsp(1'b0, 1'b0, 32'h0);
    chk_rsp("rd.c5", -1, 1'b0, 1'b0, 32'h0);

    // Collision: A write first, B read follows two cycles after A's ack.
    ra = mk_req(32'h20, 32'h55, 4'h1);
    rb = mk_req(32'h80, 32'h0, 4'hF);
    set_a(ra); set_b(rb);
    bus.i_a_req_we = 1'b1; bus.i_b_req_re = 1'b1;
    tick();
    clr_strobes();
    chk_x("col.a", ra, 1'b0, 1'b1);
    tick();
    set_rsp(1'b1, 1'b0, 32'h0);
    chk_rsp("col.ack_a", 0, 1'b1, 1'b0, 32'h0);
    tick();
    set_rsp(1'b0, 1'b0, 32'h0);
    chk_strb("col.gap", 1'b0, 1'b0);
    tick();
    chk_x("col.b", rb, 1'b1, 1'b0);
    tick();
    set_rsp(1'b1, 1'b0, 32'hCAFE_0080);
    chk_rsp("col.ack_b", 1, 1'b1, 1'b0, 32'hCAFE_0080);
    tick();
    set_rsp(1'b0, 1'b0, 32'h0);

    // Write pulse on read-only B: no strobe, switch stays idle so A is served next cycle.
    bus.i_b_req_we = 1'b1;
    tick();
    clr_strobes();
    chk_strb("ro.c2", 1'b0, 1'b0);
    tick();
    chk_strb("ro.c3", 1'b0, 1'b0);
    ra = mk_req(32'h3000, 32'h0, 4'hF);
    set_a(ra);
    bus.i_a_req_re = 1'b1;
    tick();
    clr_strobes();
    chk_x("ro.a", ra, 1'b1, 1'b0);

    // Error on A in the strobe cycle, then B served normally.
    set_rsp(1'b0, 1'b1, 32'h0);
    chk_rsp("err.a", 0, 1'b0, 1'b1, 32'h0);
    tick();
    set_rsp(1'b0, 1'b0, 32'h0);
    rb = mk_req(32'h4000, 32'h0, 4'h3);
    set_b(rb);
    bus.i_b_req_re = 1'b1;
    tick();
    clr_strobes();
    chk_x("err.b", rb, 1'b1, 1'b0);
    set_rsp(1'b1, 1'b0, 32'h1111_2222);
    chk_rsp("err.b_ack", 1, 1'b1, 1'b0, 32'h1111_2222);
    tick();
    set_rsp(1'b0, 1'b0, 32'h0);

    // Reset during BUSY_B drops the in-flight response.
    rb = mk_req(32'h5000, 32'h0, 4'hF);
    set_b(rb);
    bus.i_b_req_re = 1'b1;
    tick();
    clr_strobes();
    chk_x("rst.b", rb, 1'b1, 1'b0);
    rstn = 1'b0;
    set_rsp(1'b1, 1'b0, 32'h9999_9999);
    chk_strb("rst.low", 1'b0, 1'b0);
    chk_rsp("rst.low", -1, 1'b0, 1'b0, 32'h0);
    tick();
    rstn = 1'b1;
    #1;
    chk_rsp("rst.rel", -1, 1'b0, 1'b0, 32'h0);
    tick();
    set_rsp(1'b0, 1'b0, 32'h0);
    chk_strb("rst.idle1", 1'b0, 1'b0);
    tick();
    chk_strb("rst.idle2", 1'b0, 1'b0);

    // Randomized transactions checked against the priority/pending model.
    for (int it = 0; it < 60; it++) begin
      ra = rand_req(); rb = rand_req();
      {a_re, a_we} = 2'($urandom_range(0, 3));
      {b_re, b_we} = 2'($urandom_range(0, 3));
      inj = 1'($urandom);
      set_a(ra); set_b(rb);
      bus.i_a_req_re = a_re; bus.i_a_req_we = a_we;
      bus.i_b_req_re = b_re; bus.i_b_req_we = b_we;
      order.delete();
      exp_re[0] = a_re; exp_we[0] = a_we & !A_RO;
      exp_re[1] = b_re; exp_we[1] = b_we & !B_RO;
      if (exp_re[0] || exp_we[0]) order.push_back(0);
      if (exp_re[1] || exp_we[1]) order.push_back(1);
      tick();
      clr_strobes();
      if (order.size() == 0) begin
        chk_strb("rnd.none", 1'b0, 1'b0);
        tick();
        chk_strb("rnd.none2", 1'b0, 1'b0);
        continue;
      end
      while (order.size() > 0) begin
        p = order.pop_front();
        wait_strobe("rnd.wait");
        rq = (p == 0) ? ra : rb;
        chk_x((p == 0) ? "rnd.xa" : "rnd.xb", rq, exp_re[p], exp_we[p]);
        // A fetch strobe while A owns the bus must be held and served afterwards.
        if (p == 0 && inj && order.size() == 0) begin
          bus.i_b_req_re = 1'b1;
          exp_re[1] = 1'b1; exp_we[1] = 1'b0;
          order.push_back(1);
        end
        dly = $urandom_range(0, 2);
        for (int d = 0; d < dly; d++) begin
          tick();
          clr_strobes();
          chk_strb("rnd.hold", 1'b0, 1'b0);
          chk_rsp("rnd.hold", -1, 1'b0, 1'b0, 32'h0);
        end
        use_err = ($urandom_range(0, 3) == 0);
        rdata   = $urandom;
        set_rsp(!use_err, use_err, rdata);
        chk_rsp((p == 0) ? "rnd.rsp_a" : "rnd.rsp_b", p, !use_err, use_err, rdata);
        tick();
        clr_strobes();
        set_rsp(1'b0, 1'b0, 32'h0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
